// File: rtl/dec_report_sched.sv
// Round-robin front end that shares one binary-to-BCD nibble converter among NCH
// channels and turns each converted value into an ASCII byte stream with separators.
module dec_report_sched #(
  parameter int         NCH = 4,
  parameter int         DIG = 8,
  parameter bit         LZS = 1'b0,
  parameter logic [7:0] SEP = 8'h20,
  parameter logic [7:0] EOL = 8'h0A,
  parameter int         TMO = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NCH-1:0]     req,
  input  logic [16*NCH-1:0]  data,
  output logic [NCH-1:0]     ack,
  output logic [15:0]        bdata,
  output logic               load,
  output logic [3:0]         dig_cnt,
  input  logic [3:0]         nib_out,
  input  logic               rts,
  output logic               cts,
  output logic [7:0]         out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy,
  output logic               err
);

  localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int TW = $clog2(TMO + 1);

  typedef enum logic [1:0] {IDLE, LOAD, DIGITS, SEPST} state_t;

  state_t        state;
  logic [PW-1:0] rr;
  logic [PW-1:0] chan;
  logic [PW-1:0] winner;
  logic [PW-1:0] cand;
  logic          found;
  logic [15:0]   wdata;
  logic [3:0]    dig_idx;
  logic          zero_seen;
  logic [TW-1:0] tmo_cnt;
  logic          reg_free;
  logic          xfer;
  logic          last_dig;
  logic [7:0]    dig_byte;

  // Handshakes: a nibble moves on rts & cts; a byte moves on out_valid & out_ready.
  // The output register accepts a new byte whenever it is empty or being drained.
  assign dig_cnt  = 4'(DIG);
  assign busy     = (state != IDLE);
  assign reg_free = !out_valid || out_ready;
  assign cts      = (state == DIGITS) && reg_free;
  assign xfer     = rts && cts;
  assign last_dig = (dig_idx == 4'(DIG - 1));

  // First requester at or after the round-robin pointer, wrapping.
  always_comb begin
    found  = 1'b0;
    winner = rr;
    cand   = '0;
    for (int i = 0; i < NCH; i++) begin
      cand = PW'((int'(rr) + i) % NCH);
      if (!found && req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    wdata = '0;
    for (int k = 0; k < NCH; k++) begin
      if (PW'(k) == winner) wdata = data[16*k +: 16];
    end
  end

  // The final digit is always numeric so a zero value still prints "0".
  always_comb begin
    if (nib_out > 4'd9)
      dig_byte = 8'h3F;
    else if (LZS && (nib_out == 4'd0) && !zero_seen && !last_dig)
      dig_byte = 8'h20;
    else
      dig_byte = 8'h30 + {4'h0, nib_out};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rr        <= '0;
      chan      <= '0;
      ack       <= '0;
      load      <= 1'b0;
      bdata     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      err       <= 1'b0;
      dig_idx   <= '0;
      zero_seen <= 1'b0;
      tmo_cnt   <= '0;
    end else begin
      ack  <= '0;
      load <= 1'b0;
      if (out_valid && out_ready) out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            bdata <= wdata;
            ack   <= NCH'(1) << winner;
            chan  <= winner;
            rr    <= (winner == PW'(NCH - 1)) ? '0 : winner + 1'b1;
            load  <= 1'b1;
            state <= LOAD;
          end
        end
        LOAD: begin
          dig_idx   <= '0;
          zero_seen <= 1'b0;
          tmo_cnt   <= '0;
          state     <= DIGITS;
        end
        DIGITS: begin
          if (xfer) begin
            out_data  <= dig_byte;
            out_valid <= 1'b1;
            if (nib_out > 4'd9) err <= 1'b1;
            if (nib_out != 4'd0) zero_seen <= 1'b1;
            tmo_cnt <= '0;
            dig_idx <= dig_idx + 4'd1;
            if (last_dig) state <= SEPST;
          end else if (tmo_cnt == TW'(TMO - 1)) begin
            // Stalled converter: abandon the remaining digits.
            err   <= 1'b1;
            state <= SEPST;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        SEPST: begin
          if (reg_free) begin
            out_data  <= (chan == PW'(NCH - 1)) ? EOL : SEP;
            out_valid <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
